// File: rtl/jk_bank_sequencer_if.sv
// jk_bank_sequencer_if
//   Command handshake between the control logic (master) and the JK bank
//   sequencer (slave). A command is accepted on the rising clock edge where
//   cmd_valid and cmd_ready are both high.
//   Signals:
//     cmd_valid  master -> slave  command present
//     cmd_ready  slave -> master  sequencer can accept a command
//     cmd_op     master -> slave  00 clear, 01 load, 10 count up, 11 count down
//     cmd_data   master -> slave  load value or step count (WIDTH bits)
interface jk_bank_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer
//   Drives the J/K inputs of a WIDTH-bit bank of JK flip-flops to clear it,
//   load it, or count it up/down modulo MOD for a number of steps, then reads
//   the bank back and reports done/err.
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous reset, active low
//     cmd        command handshake (slave side of jk_bank_sequencer_if)
//     q_in       Q outputs of the JK bank
//     j_out      J inputs to the JK bank
//     k_out      K inputs to the JK bank
//     busy       command in progress
//     done       one-cycle pulse when a command finishes
//     err        one-cycle pulse with done when the command failed
//     wrap       one-cycle pulse while a wrapping count step is driven
module jk_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic                clk,
  input  logic                rst,
  jk_bank_sequencer_if.slave  cmd,
  input  logic [WIDTH-1:0]    q_in,
  output logic [WIDTH-1:0]    j_out,
  output logic [WIDTH-1:0]    k_out,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    RUN   = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_UP    = 2'b10;

  // Modulus arithmetic is done one bit wider so MOD = 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0]   MOD_M1 = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH:0]   ONE_W  = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] ONE_N  = WIDTH'(1);

  state_t           state, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic             force_err_q, force_err_d;
  logic             live_q;

  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   next_ext;
  logic [WIDTH-1:0] next_val;
  logic             step_wrap;
  logic             load_ok;

  assign q_ext    = {1'b0, q_in};
  assign next_val = next_ext[WIDTH-1:0];
  assign load_ok  = ({1'b0, data_q} < MOD_W);
  assign busy     = (state != IDLE);

  // live_q holds cmd_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      op_q        <= '0;
      data_q      <= '0;
      steps_q     <= '0;
      expected_q  <= '0;
      force_err_q <= 1'b0;
      live_q      <= 1'b0;
    end else begin
      state       <= state_d;
      op_q        <= op_d;
      data_q      <= data_d;
      steps_q     <= steps_d;
      expected_q  <= expected_d;
      force_err_q <= force_err_d;
      live_q      <= 1'b1;
    end
  end

  // Next bank value for one count step. Out-of-range bank values snap to the
  // wrap target without flagging a wrap.
  always_comb begin
    next_ext  = '0;
    step_wrap = 1'b0;
    if (op_q == OP_UP) begin
      if (q_ext == MOD_M1) begin
        next_ext  = '0;
        step_wrap = 1'b1;
      end else if (q_ext >= MOD_W) begin
        next_ext  = '0;
      end else begin
        next_ext  = q_ext + ONE_W;
      end
    end else begin
      if (q_ext == '0) begin
        next_ext  = MOD_M1;
        step_wrap = 1'b1;
      end else if (q_ext >= MOD_W) begin
        next_ext  = MOD_M1;
      end else begin
        next_ext  = q_ext - ONE_W;
      end
    end
  end

  // The bank samples j/k on the same edge the FSM advances, so q_in shows the
  // effect of an APPLY/RUN cycle in the following state.
  always_comb begin
    state_d       = state;
    op_d          = op_q;
    data_d        = data_q;
    steps_d       = steps_q;
    expected_d    = expected_q;
    force_err_d   = force_err_q;
    j_out         = '0;
    k_out         = '0;
    cmd.cmd_ready = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    wrap          = 1'b0;
    case (state)
      IDLE: begin
        cmd.cmd_ready = live_q;
        if (cmd.cmd_valid && live_q) begin
          op_d        = cmd.cmd_op;
          data_d      = cmd.cmd_data;
          force_err_d = 1'b0;
          state_d     = APPLY;
        end
      end
      APPLY: begin
        case (op_q)
          OP_CLEAR: begin
            k_out      = '1;
            expected_d = '0;
            state_d    = CHECK;
          end
          OP_LOAD: begin
            if (load_ok) begin
              j_out      = data_q;
              k_out      = ~data_q;
              expected_d = data_q;
            end else begin
              force_err_d = 1'b1;
            end
            state_d = CHECK;
          end
          default: begin
            steps_d = data_q;
            if (data_q == '0) begin
              expected_d = q_in;
              state_d    = CHECK;
            end else begin
              state_d    = RUN;
            end
          end
        endcase
      end
      RUN: begin
        // Toggling exactly the bits that differ moves the bank to next_val.
        j_out      = q_in ^ next_val;
        k_out      = q_in ^ next_val;
        expected_d = next_val;
        wrap       = step_wrap;
        steps_d    = steps_q - ONE_N;
        if (steps_q == ONE_N) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        done    = 1'b1;
        err     = force_err_q || (q_in != expected_q);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// tb_jk_bank_sequencer
//   Bench for jk_bank_sequencer with a behavioural JK bank (with optional
//   stuck-at-0 bits on its outputs) and an arithmetic model of the bank value
//   that predicts latency, wrap count, err and the final bank value.
module tb_jk_bank_sequencer;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] j_out;
  logic [WIDTH-1:0] k_out;
  logic [WIDTH-1:0] bank = '0;
  logic [WIDTH-1:0] stuck = '0;
  logic             busy;
  logic             done;
  logic             err;
  logic             wrap;

  int checks = 0;
  int errors = 0;
  int model_val = 0;

  jk_bank_sequencer_if #(.WIDTH(WIDTH)) cmd_if ();

  jk_bank_sequencer #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk   (clk),
    .rst   (rst),
    .cmd   (cmd_if),
    .q_in  (q_in),
    .j_out (j_out),
    .k_out (k_out),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .wrap  (wrap)
  );

  always #5 clk = ~clk;

  // JK bank: Q+ = J & ~Q | ~K & Q per bit; stuck bits read back as 0.
  always @(posedge clk) bank <= (j_out & ~bank) | (~k_out & bank);
  assign q_in = bank & ~stuck;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Presents a command and returns 1 time unit after the accepting edge.
  task automatic sendCmd(input logic [1:0] op, input logic [WIDTH-1:0] data);
    bit accepted;
    accepted = 1'b0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    for (int i = 0; i < 20; i++) begin
      if (cmd_if.cmd_ready) begin
        @(posedge clk);
        #1;
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
    if (!accepted) checkOutput("accept_timeout", int'(cmd_if.cmd_ready), 1);
  endtask

  // Follows a command from the cycle after accept until done, counting cycles
  // and wrap pulses; optionally pokes cmd_valid while the block is busy.
  task automatic waitDone(input bit poke, output int cycles, output int wraps,
                          output int err_seen, output int q_seen, output int ready_bad);
    bit found;
    found     = 1'b0;
    cycles    = 1;
    wraps     = 0;
    err_seen  = 0;
    q_seen    = 0;
    ready_bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (wrap) wraps++;
      if (cmd_if.cmd_ready) ready_bad++;
      if (done) begin
        err_seen = int'(err);
        q_seen   = int'(q_in);
        cmd_if.cmd_valid = 1'b0;
        found = 1'b1;
        break;
      end
      if (poke) begin
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b00;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    cmd_if.cmd_valid = 1'b0;
    if (!found) checkOutput("done_timeout", int'(done), 1);
  endtask

  // Runs one command end to end and compares against the arithmetic model.
  task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] data, input bit poke);
    logic [WIDTH-1:0] exp_j;
    logic [WIDTH-1:0] exp_k;
    int exp_wraps, exp_err, exp_lat, v;
    int cycles, wraps, err_seen, q_seen, ready_bad;
    exp_j = '0;
    exp_k = '0;
    exp_wraps = 0;
    exp_err = 0;
    v = model_val;
    exp_lat = (op[1]) ? int'(data) + 2 : 2;
    case (op)
      2'b00: begin
        exp_k = '1;
        v = 0;
      end
      2'b01: begin
        if (int'(data) < MOD) begin
          exp_j = data;
          exp_k = ~data;
          v = int'(data);
        end else begin
          exp_err = 1;
        end
      end
      2'b10: begin
        for (int n = 0; n < int'(data); n++) begin
          if (v == MOD - 1) exp_wraps++;
          v = (v + 1) % MOD;
        end
      end
      default: begin
        for (int n = 0; n < int'(data); n++) begin
          if (v == 0) exp_wraps++;
          v = (v + MOD - 1) % MOD;
        end
      end
    endcase

    sendCmd(op, data);
    checkOutput("apply_j", int'(j_out), int'(exp_j));
    checkOutput("apply_k", int'(k_out), int'(exp_k));
    checkOutput("apply_busy", int'(busy), 1);
    waitDone(poke, cycles, wraps, err_seen, q_seen, ready_bad);
    checkOutput("latency", cycles, exp_lat);
    checkOutput("wrap_count", wraps, exp_wraps);
    checkOutput("err", err_seen, exp_err);
    checkOutput("final_q", q_seen, v);
    checkOutput("ready_while_busy", ready_bad, 0);
    model_val = v;
    @(posedge clk);
    #1;
    checkOutput("done_pulse_width", int'(done), 0);
    checkOutput("ready_after_done", int'(cmd_if.cmd_ready), 1);
    checkOutput("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int cycles, wraps, err_seen, q_seen, ready_bad;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    bit               r_poke;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_data  = '0;

    // Reset state
    #2;
    checkOutput("rst_j", int'(j_out), 0);
    checkOutput("rst_k", int'(k_out), 0);
    checkOutput("rst_ready", int'(cmd_if.cmd_ready), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_err", int'(err), 0);
    checkOutput("rst_wrap", int'(wrap), 0);
    repeat (2) @(negedge clk);
    checkOutput("rst_ready_held", int'(cmd_if.cmd_ready), 0);
    rst = 1'b1;
    #1;
    checkOutput("release_ready_before_edge", int'(cmd_if.cmd_ready), 0);
    @(posedge clk);
    #1;
    checkOutput("release_ready_after_edge", int'(cmd_if.cmd_ready), 1);

    // Directed sequence
    applyStimulus(2'b00, 4'd0, 1'b0);
    applyStimulus(2'b01, 4'd7, 1'b0);
    applyStimulus(2'b10, 4'd5, 1'b0);
    applyStimulus(2'b01, 4'd0, 1'b0);
    applyStimulus(2'b11, 4'd3, 1'b0);
    applyStimulus(2'b01, 4'd12, 1'b0);
    applyStimulus(2'b10, 4'd0, 1'b0);
    applyStimulus(2'b10, 4'd6, 1'b1);

    // Stuck-at-0 bank bit: counting 1 -> 2 reads back 0
    applyStimulus(2'b01, 4'd1, 1'b0);
    stuck = 4'b0010;
    sendCmd(2'b10, 4'd1);
    waitDone(1'b0, cycles, wraps, err_seen, q_seen, ready_bad);
    checkOutput("stuck_latency", cycles, 3);
    checkOutput("stuck_err", err_seen, 1);
    @(posedge clk);
    #1;
    stuck = '0;
    applyStimulus(2'b00, 4'd0, 1'b0);

    // Randomized commands
    for (int n = 0; n < 60; n++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_data = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      r_poke = 1'($urandom_range(0, 1));
      applyStimulus(r_op, r_data, r_poke);
    end

    // Reset in the middle of a count: bank freezes at the value reached
    applyStimulus(2'b01, 4'd2, 1'b0);
    sendCmd(2'b10, 4'd6);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("pre_reset_q", int'(q_in), 4);
    rst = 1'b0;
    #1;
    checkOutput("midrst_j", int'(j_out), 0);
    checkOutput("midrst_k", int'(k_out), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_ready", int'(cmd_if.cmd_ready), 0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkOutput("midrst_no_done", int'(done), 0);
      checkOutput("midrst_bank_frozen", int'(q_in), 4);
    end
    model_val = 4;
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready_before_edge", int'(cmd_if.cmd_ready), 0);
    @(posedge clk);
    #1;
    checkOutput("midrst_ready_after_edge", int'(cmd_if.cmd_ready), 1);
    applyStimulus(2'b11, 4'd2, 1'b0);
    applyStimulus(2'b10, 4'd9, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_bank_sequencer.md
Name: jk_bank_sequencer

Overview:
- Sequencer for a bank of WIDTH JK flip-flops (one per bit, instantiated beside this block).
- Each cycle it drives the bank's J/K vectors to execute commands: clear, load, or count up/down modulo MOD for N steps.
- After each command it reads back the bank outputs and reports done/err.
- Accepts commands over a valid/ready handshake from the surrounding control logic.

Parameters:
WIDTH, 4, bank width in bits (1..16)
MOD, 10, count modulus (2..2^WIDTH); legal bank values 0..MOD-1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_op  input  2  00 clear, 01 load, 10 count up, 11 count down
cmd_data  input  WIDTH  load value (op 01) or step count (ops 10/11); ignored for op 00
q_in  input  WIDTH  Q outputs of the JK bank
j_out  output  WIDTH  J inputs to the JK bank
k_out  output  WIDTH  K inputs to the JK bank
busy  output  1  command in progress (state != IDLE)
done  output  1  one-cycle pulse, command finished
err  output  1  one-cycle pulse, coincident with done, on command failure
wrap  output  1  one-cycle pulse in the cycle a wrapping count step is driven

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, step counter 0, expected register 0.
  - Outputs during reset: j_out=k_out=0 (bank holds), cmd_ready=0, busy=done=err=wrap=0.
  - After rst deasserts, cmd_ready=1 from the first clock edge onward.
- Reset mid-command aborts it immediately; the bank keeps its current value; no done is issued.
- j_out/k_out are combinational from the registered state and q_in. The bank samples them on the same edge the FSM advances, so q_in reflects a step one cycle later.
- States: IDLE, APPLY, RUN, CHECK.
- IDLE:
  - cmd_ready=1, j_out=k_out=0.
  - On cmd_valid&cmd_ready, latch op/data and go to APPLY.
  - cmd_valid while busy is ignored; the source must hold it.
- APPLY (exactly 1 cycle):
  - Clear: j_out=0, k_out=all ones; expected=0; go to CHECK.
  - Load with data<MOD: j_out=data, k_out=~data; expected=data; go to CHECK.
  - Load with data>=MOD: j_out=k_out=0; go to CHECK with a forced error.
  - Count: j_out=k_out=0; steps=data.
    - If data==0, go to CHECK with expected=q_in (no change).
    - Otherwise go to RUN.
- RUN (one step per cycle):
  - next value, up: q_in==MOD-1 gives 0 with wrap=1; q_in>=MOD gives 0 with wrap=0; otherwise q_in+1.
  - next value, down: q_in==0 gives MOD-1 with wrap=1; q_in>=MOD gives MOD-1 with wrap=0; otherwise q_in-1.
  - Drive j_out=k_out=q_in^next (toggle mask) and set expected=next.
  - Decrement steps; when steps reaches 0 in this cycle, go to CHECK.
- CHECK (1 cycle):
  - j_out=k_out=0.
  - Compare q_in with expected: done=1; err=1 on mismatch or forced error.
  - Go to IDLE. cmd_ready returns to 1 the following cycle, so back-to-back commands have a 1-cycle gap.
- Latency:
  - Clear/load: accept to done = 2 cycles.
  - Count: data+2 cycles.
  - Count with data=0: 2 cycles.
- Arithmetic: next is computed in WIDTH+1 bits to avoid overflow when MOD=2^WIDTH, then truncated to WIDTH.
- wrap is only asserted in RUN; it is never asserted by clear/load.

Test Plan:
- WIDTH=4, MOD=10: rst=0 then 1; clear -> j_out=0, k_out=1111 for 1 cycle; q_in reads 0; done=1, err=0 two cycles after accept.
- Load 7 -> j_out=0111, k_out=1000; done; count up 5 -> bank sequence 8,9,0,1,2; wrap pulses once on the 9->0 step; done with err=0 at accept+7.
- Load 0, count down 3 -> sequence 9,8,7; wrap on the first step; final q_in=7; no err.
- Load 12 (>=MOD) -> j_out=k_out=0; done with err=1; bank unchanged. Count 0 steps -> done after 2 cycles; j/k stay 0.
- Assert cmd_valid during RUN -> ignored, cmd_ready=0. Pull rst low mid-RUN -> j_out=k_out=0 immediately; no done; bank frozen; next command accepted after release.
- Model a bank bit stuck at 0 during count up from 1 -> CHECK mismatch produces done=1, err=1.
